// File: rtl/mmu_tlb_pkg.sv
// Shared constants, entry layout and address-segment helpers for the MIPS-style TLB.
package mmu_tlb_pkg;

    localparam int unsigned VADDR_W    = 32;
    localparam int unsigned PAGE_OFS_W = 12;
    localparam int unsigned VPN_W      = 20;
    localparam int unsigned PFN_W      = 20;
    localparam int unsigned ASID_MAX_W = 16;

    localparam logic [VADDR_W-1:0] KSEG0_BASE = 32'h8000_0000;
    localparam logic [VADDR_W-1:0] KSEG1_BASE = 32'hA000_0000;
    localparam logic [VADDR_W-1:0] KSEG_MASK  = 32'h1FFF_FFFF;

    // Fields the compare banks look at; kept separate so matchers only see tags.
    typedef struct packed {
        logic [VPN_W-1:0]      vpn;
        logic [ASID_MAX_W-1:0] asid;
        logic                  g;
        logic                  v;
    } tlb_tag_t;

    typedef struct packed {
        tlb_tag_t          tag;
        logic [PFN_W-1:0]  pfn;
        logic              c;
        logic              d;
    } tlb_entry_t;

    function automatic logic is_kseg0(input logic [VADDR_W-1:0] va);
        return (va & ~KSEG_MASK) == KSEG0_BASE;
    endfunction

    function automatic logic is_kseg1(input logic [VADDR_W-1:0] va);
        return (va & ~KSEG_MASK) == KSEG1_BASE;
    endfunction

    function automatic logic is_mapped(input logic [VADDR_W-1:0] va);
        return !(is_kseg0(va) || is_kseg1(va));
    endfunction

    function automatic logic [VADDR_W-1:0] xlate_paddr(input logic [VADDR_W-1:0] va,
                                                       input logic hit,
                                                       input logic [PFN_W-1:0] pfn);
        if (!is_mapped(va)) return va & KSEG_MASK;
        if (hit)            return {pfn, va[PAGE_OFS_W-1:0]};
        return '0;
    endfunction

    function automatic logic xlate_uncached(input logic [VADDR_W-1:0] va,
                                            input logic hit,
                                            input logic c);
        if (is_kseg1(va)) return 1'b1;
        if (is_kseg0(va)) return 1'b0;
        return hit && !c;
    endfunction

endpackage

// File: rtl/mmu_tlb_match.sv
// Single-port fully-associative tag compare with lowest-index priority encode.
module tlb_match
    import mmu_tlb_pkg::*;
#(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  tlb_tag_t              tags_i [ENTRIES],
    input  logic [VPN_W-1:0]      vpn_i,
    input  logic [ASID_MAX_W-1:0] asid_i,
    output logic                  hit_c,
    output logic [IDX_W-1:0]      idx_c
);

    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (tags_i[i].v && (tags_i[i].vpn == vpn_i) &&
                (tags_i[i].g || (tags_i[i].asid == asid_i))) begin
                hit_c = 1'b1;
                idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mmu_tlb.sv
// Fully-associative TLB with kseg0/kseg1 bypass, registered inst/data/probe responses
// and a wired-bounded random replacement index.
module mmu_tlb
    import mmu_tlb_pkg::*;
#(
    parameter int unsigned TLB_ENTRIES = 8,
    parameter int unsigned ASID_W      = 8,
    parameter int unsigned IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [ASID_W-1:0] cur_asid,
    input  logic              inst_req,
    input  logic [31:0]       inst_vaddr,
    output logic              inst_valid,
    output logic [31:0]       inst_paddr,
    output logic              inst_miss,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [31:0]       data_vaddr,
    output logic              data_valid,
    output logic [31:0]       data_paddr,
    output logic              data_uncached,
    output logic              data_miss,
    output logic              data_mod,
    input  logic              tlb_we,
    input  logic [IDX_W-1:0]  tlb_idx,
    input  logic [19:0]       tlb_vpn,
    input  logic [ASID_W-1:0] tlb_asid,
    input  logic              tlb_g,
    input  logic [19:0]       tlb_pfn,
    input  logic              tlb_c,
    input  logic              tlb_d,
    input  logic              tlb_v,
    input  logic              tlbp_req,
    input  logic [19:0]       tlbp_vpn,
    output logic              tlbp_valid,
    output logic [IDX_W-1:0]  tlbp_idx,
    output logic              tlbp_miss,
    input  logic              tlb_flush,
    input  logic [IDX_W-1:0]  wired,
    output logic [IDX_W-1:0]  random_idx
);

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TLB_ENTRIES - 1);

    tlb_entry_t entries_q [TLB_ENTRIES];
    tlb_entry_t entries_d [TLB_ENTRIES];
    tlb_tag_t   tag_c     [TLB_ENTRIES];

    logic [ASID_MAX_W-1:0] asid_ext_c;
    logic                  inst_hit_c, data_hit_c, tlbp_hit_c;
    logic [IDX_W-1:0]      inst_idx_c, data_idx_c, tlbp_idx_c;

    logic              inst_valid_q, inst_valid_d, inst_miss_q, inst_miss_d;
    logic [31:0]       inst_paddr_q, inst_paddr_d;
    logic              data_valid_q, data_valid_d, data_miss_q, data_miss_d;
    logic              data_uncached_q, data_uncached_d, data_mod_q, data_mod_d;
    logic [31:0]       data_paddr_q, data_paddr_d;
    logic              tlbp_valid_q, tlbp_valid_d, tlbp_miss_q, tlbp_miss_d;
    logic [IDX_W-1:0]  tlbp_idx_q, tlbp_idx_d;
    logic [IDX_W-1:0]  random_q, random_d;

    assign asid_ext_c = ASID_MAX_W'(cur_asid);

    always_comb begin
        for (int i = 0; i < int'(TLB_ENTRIES); i++) tag_c[i] = entries_q[i].tag;
    end

    tlb_match #(.ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_inst_match (
        .tags_i (tag_c), .vpn_i (inst_vaddr[31:12]), .asid_i (asid_ext_c),
        .hit_c  (inst_hit_c), .idx_c (inst_idx_c)
    );

    tlb_match #(.ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_data_match (
        .tags_i (tag_c), .vpn_i (data_vaddr[31:12]), .asid_i (asid_ext_c),
        .hit_c  (data_hit_c), .idx_c (data_idx_c)
    );

    tlb_match #(.ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_tlbp_match (
        .tags_i (tag_c), .vpn_i (tlbp_vpn), .asid_i (asid_ext_c),
        .hit_c  (tlbp_hit_c), .idx_c (tlbp_idx_c)
    );

    // Flush first, then the write, so an entry written alongside a flush survives.
    always_comb begin
        entries_d = entries_q;
        if (tlb_flush) begin
            for (int i = 0; i < int'(TLB_ENTRIES); i++) entries_d[i].tag.v = 1'b0;
        end
        if (tlb_we) begin
            entries_d[tlb_idx].tag.vpn  = tlb_vpn;
            entries_d[tlb_idx].tag.asid = ASID_MAX_W'(tlb_asid);
            entries_d[tlb_idx].tag.g    = tlb_g;
            entries_d[tlb_idx].tag.v    = tlb_v;
            entries_d[tlb_idx].pfn      = tlb_pfn;
            entries_d[tlb_idx].c        = tlb_c;
            entries_d[tlb_idx].d        = tlb_d;
        end
    end

    // Responses: valid follows the request; payload only reloads on an accepted request.
    always_comb begin
        inst_valid_d    = inst_valid_q;
        inst_paddr_d    = inst_paddr_q;
        inst_miss_d     = inst_miss_q;
        data_valid_d    = data_valid_q;
        data_paddr_d    = data_paddr_q;
        data_uncached_d = data_uncached_q;
        data_miss_d     = data_miss_q;
        data_mod_d      = data_mod_q;
        tlbp_valid_d    = tlbp_valid_q;
        tlbp_idx_d      = tlbp_idx_q;
        tlbp_miss_d     = tlbp_miss_q;
        if (!stall) begin
            inst_valid_d = inst_req;
            data_valid_d = data_req;
            tlbp_valid_d = tlbp_req;
            if (inst_req) begin
                inst_paddr_d = xlate_paddr(inst_vaddr, inst_hit_c, entries_q[inst_idx_c].pfn);
                inst_miss_d  = is_mapped(inst_vaddr) && !inst_hit_c;
            end
            if (data_req) begin
                data_paddr_d    = xlate_paddr(data_vaddr, data_hit_c, entries_q[data_idx_c].pfn);
                data_uncached_d = xlate_uncached(data_vaddr, data_hit_c, entries_q[data_idx_c].c);
                data_miss_d     = is_mapped(data_vaddr) && !data_hit_c;
                data_mod_d      = is_mapped(data_vaddr) && data_hit_c && data_wr &&
                                  !entries_q[data_idx_c].d;
            end
            if (tlbp_req) begin
                tlbp_idx_d  = tlbp_idx_c;
                tlbp_miss_d = !tlbp_hit_c;
            end
        end
    end

    // Random index counts down to wired, then wraps; any write or out-of-range value reloads.
    always_comb begin
        random_d = random_q;
        if (!stall) begin
            if (tlb_we || (random_q <= wired)) random_d = IDX_MAX;
            else                               random_d = random_q - IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q       <= '{default: '0};
            inst_valid_q    <= 1'b0;
            inst_paddr_q    <= '0;
            inst_miss_q     <= 1'b0;
            data_valid_q    <= 1'b0;
            data_paddr_q    <= '0;
            data_uncached_q <= 1'b0;
            data_miss_q     <= 1'b0;
            data_mod_q      <= 1'b0;
            tlbp_valid_q    <= 1'b0;
            tlbp_idx_q      <= '0;
            tlbp_miss_q     <= 1'b0;
            random_q        <= IDX_MAX;
        end else begin
            entries_q       <= entries_d;
            inst_valid_q    <= inst_valid_d;
            inst_paddr_q    <= inst_paddr_d;
            inst_miss_q     <= inst_miss_d;
            data_valid_q    <= data_valid_d;
            data_paddr_q    <= data_paddr_d;
            data_uncached_q <= data_uncached_d;
            data_miss_q     <= data_miss_d;
            data_mod_q      <= data_mod_d;
            tlbp_valid_q    <= tlbp_valid_d;
            tlbp_idx_q      <= tlbp_idx_d;
            tlbp_miss_q     <= tlbp_miss_d;
            random_q        <= random_d;
        end
    end

    assign inst_valid    = inst_valid_q;
    assign inst_paddr    = inst_paddr_q;
    assign inst_miss     = inst_miss_q;
    assign data_valid    = data_valid_q;
    assign data_paddr    = data_paddr_q;
    assign data_uncached = data_uncached_q;
    assign data_miss     = data_miss_q;
    assign data_mod      = data_mod_q;
    assign tlbp_valid    = tlbp_valid_q;
    assign tlbp_idx      = tlbp_idx_q;
    assign tlbp_miss     = tlbp_miss_q;
    assign random_idx    = random_q;

endmodule

// File: tb/tb_mmu_tlb.sv
// Directed vector bench for mmu_tlb: segment bypass, TLB lookups, probe, flush, random index, reset.
module tb_mmu_tlb;

    logic        clk, rst_n, stall;
    logic [7:0]  cur_asid;
    logic        inst_req;
    logic [31:0] inst_vaddr;
    logic        inst_valid, inst_miss;
    logic [31:0] inst_paddr;
    logic        data_req, data_wr;
    logic [31:0] data_vaddr;
    logic        data_valid, data_uncached, data_miss, data_mod;
    logic [31:0] data_paddr;
    logic        tlb_we;
    logic [2:0]  tlb_idx;
    logic [19:0] tlb_vpn;
    logic [7:0]  tlb_asid;
    logic        tlb_g, tlb_c, tlb_d, tlb_v;
    logic [19:0] tlb_pfn;
    logic        tlbp_req;
    logic [19:0] tlbp_vpn;
    logic        tlbp_valid, tlbp_miss;
    logic [2:0]  tlbp_idx;
    logic        tlb_flush;
    logic [2:0]  wired;
    logic [2:0]  random_idx;

    int checks = 0;
    int failures = 0;

    mmu_tlb dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .cur_asid(cur_asid),
        .inst_req(inst_req), .inst_vaddr(inst_vaddr),
        .inst_valid(inst_valid), .inst_paddr(inst_paddr), .inst_miss(inst_miss),
        .data_req(data_req), .data_wr(data_wr), .data_vaddr(data_vaddr),
        .data_valid(data_valid), .data_paddr(data_paddr), .data_uncached(data_uncached),
        .data_miss(data_miss), .data_mod(data_mod),
        .tlb_we(tlb_we), .tlb_idx(tlb_idx), .tlb_vpn(tlb_vpn), .tlb_asid(tlb_asid),
        .tlb_g(tlb_g), .tlb_pfn(tlb_pfn), .tlb_c(tlb_c), .tlb_d(tlb_d), .tlb_v(tlb_v),
        .tlbp_req(tlbp_req), .tlbp_vpn(tlbp_vpn),
        .tlbp_valid(tlbp_valid), .tlbp_idx(tlbp_idx), .tlbp_miss(tlbp_miss),
        .tlb_flush(tlb_flush), .wired(wired), .random_idx(random_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] iva;
        logic        dreq;
        logic        dwr;
        logic [31:0] dva;
        logic [7:0]  asid;
        logic        e_iv;
        logic [31:0] e_ipa;
        logic        e_im;
        logic        e_dv;
        logic [31:0] e_dpa;
        logic        e_du;
        logic        e_dm;
        logic        e_dmod;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_entry(input logic [2:0] idx, input logic [19:0] vpn, input logic [7:0] asid,
                            input logic g, input logic [19:0] pfn, input logic c,
                            input logic d, input logic v);
        tlb_we = 1'b1; tlb_idx = idx; tlb_vpn = vpn; tlb_asid = asid;
        tlb_g = g; tlb_pfn = pfn; tlb_c = c; tlb_d = d; tlb_v = v;
        step();
        tlb_we = 1'b0;
    endtask

    task automatic data_ld(input logic [31:0] va);
        data_req = 1'b1; data_wr = 1'b0; data_vaddr = va;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; cur_asid = 8'd0;
        inst_req = 1'b0; inst_vaddr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_vaddr = '0;
        tlb_we = 1'b0; tlb_idx = '0; tlb_vpn = '0; tlb_asid = '0;
        tlb_g = 1'b0; tlb_pfn = '0; tlb_c = 1'b0; tlb_d = 1'b0; tlb_v = 1'b0;
        tlbp_req = 1'b0; tlbp_vpn = '0; tlb_flush = 1'b0; wired = 3'd0;

        //                ireq iva           dreq dwr dva           asid  iv ipa           im dv dpa           du dm dmod
        vecs[0] = '{1'b1, 32'hBFC0_0000, 1'b1, 1'b0, 32'h8000_1234, 8'd5, 1'b1, 32'h1FC0_0000, 1'b0, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'hA000_0010, 1'b1, 1'b0, 32'h0040_0ABC, 8'd5, 1'b1, 32'h0000_0010, 1'b0, 1'b1, 32'h0123_4ABC, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h0050_0004, 1'b1, 1'b1, 32'h0040_0ABC, 8'd5, 1'b1, 32'hABCD_E004, 1'b0, 1'b1, 32'h0123_4ABC, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 32'h0060_0000, 1'b1, 1'b0, 32'h0040_0ABC, 8'd6, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0050_0FFF, 8'd6, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'hABCD_EFFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h7FFF_F000, 1'b1, 1'b0, 32'hA000_1000, 8'd6, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_1000, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 8'd6, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_1000, 1'b1, 1'b0, 1'b0};

        // Reset state
        step(); step();
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_random", 32'(random_idx), 32'd7);
        #2 rst_n = 1'b1;
        step();
        chk("rst_inst_paddr", inst_paddr, 32'd0);
        chk("rst_data_miss", 32'(data_miss), 32'd0);
        chk("rst_tlbp_valid", 32'(tlbp_valid), 32'd0);
        chk("rst_data_uncached", 32'(data_uncached), 32'd0);

        wr_entry(3'd3, 20'h00400, 8'd5, 1'b0, 20'h01234, 1'b1, 1'b0, 1'b1);
        wr_entry(3'd0, 20'h00500, 8'd0, 1'b1, 20'hABCDE, 1'b0, 1'b1, 1'b1);
        wr_entry(3'd4, 20'h00600, 8'd5, 1'b1, 20'h00042, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 7; i++) begin
            inst_req = vecs[i].ireq; inst_vaddr = vecs[i].iva;
            data_req = vecs[i].dreq; data_wr = vecs[i].dwr; data_vaddr = vecs[i].dva;
            cur_asid = vecs[i].asid;
            step();
            chk($sformatf("v%0d_inst_valid", i), 32'(inst_valid), 32'(vecs[i].e_iv));
            chk($sformatf("v%0d_inst_paddr", i), inst_paddr, vecs[i].e_ipa);
            chk($sformatf("v%0d_inst_miss", i), 32'(inst_miss), 32'(vecs[i].e_im));
            chk($sformatf("v%0d_data_valid", i), 32'(data_valid), 32'(vecs[i].e_dv));
            chk($sformatf("v%0d_data_paddr", i), data_paddr, vecs[i].e_dpa);
            chk($sformatf("v%0d_data_uncached", i), 32'(data_uncached), 32'(vecs[i].e_du));
            chk($sformatf("v%0d_data_miss", i), 32'(data_miss), 32'(vecs[i].e_dm));
            chk($sformatf("v%0d_data_mod", i), 32'(data_mod), 32'(vecs[i].e_dmod));
        end
        inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;

        // Duplicate matches resolve to the lowest index; flush empties the TLB
        cur_asid = 8'd5;
        wr_entry(3'd6, 20'h00010, 8'd0, 1'b1, 20'h00001, 1'b1, 1'b1, 1'b1);
        wr_entry(3'd2, 20'h00010, 8'd0, 1'b1, 20'h00002, 1'b1, 1'b1, 1'b1);
        tlbp_req = 1'b1; tlbp_vpn = 20'h00010;
        step();
        chk("probe_dup_valid", 32'(tlbp_valid), 32'd1);
        chk("probe_dup_idx", 32'(tlbp_idx), 32'd2);
        chk("probe_dup_miss", 32'(tlbp_miss), 32'd0);
        tlbp_vpn = 20'h00400;
        step();
        chk("probe_asid_idx", 32'(tlbp_idx), 32'd3);
        tlbp_req = 1'b0; tlb_flush = 1'b1;
        step();
        chk("probe_idle_valid", 32'(tlbp_valid), 32'd0);
        tlb_flush = 1'b0; tlbp_req = 1'b1; tlbp_vpn = 20'h00010;
        step();
        chk("probe_flush_miss", 32'(tlbp_miss), 32'd1);
        chk("probe_flush_idx", 32'(tlbp_idx), 32'd0);
        tlbp_req = 1'b0;

        // Lookup in the write cycle sees old contents; next cycle hits
        tlb_we = 1'b1; tlb_idx = 3'd1; tlb_vpn = 20'h00777; tlb_asid = 8'd0;
        tlb_g = 1'b1; tlb_pfn = 20'h00111; tlb_c = 1'b1; tlb_d = 1'b1; tlb_v = 1'b1;
        data_ld(32'h0077_7008);
        step();
        chk("wr_same_cycle_miss", 32'(data_miss), 32'd1);
        chk("wr_same_cycle_paddr", data_paddr, 32'd0);
        tlb_we = 1'b0;
        step();
        chk("wr_next_cycle_miss", 32'(data_miss), 32'd0);
        chk("wr_next_cycle_paddr", data_paddr, 32'h0011_1008);

        // Flush with a concurrent write keeps only the written entry
        data_req = 1'b0; tlb_flush = 1'b1;
        wr_entry(3'd5, 20'h00999, 8'd0, 1'b1, 20'h00333, 1'b1, 1'b1, 1'b1);
        tlb_flush = 1'b0;
        data_ld(32'h0099_9000); tlbp_req = 1'b1; tlbp_vpn = 20'h00777;
        step();
        chk("flush_we_survive_paddr", data_paddr, 32'h0033_3000);
        chk("flush_we_survive_miss", 32'(data_miss), 32'd0);
        chk("flush_we_other_gone", 32'(tlbp_miss), 32'd1);
        tlbp_req = 1'b0;

        // Stall holds responses while the write still lands
        stall = 1'b1; data_ld(32'h8000_0004);
        wr_entry(3'd0, 20'h00888, 8'd0, 1'b1, 20'h00222, 1'b1, 1'b1, 1'b1);
        chk("stall_hold_paddr", data_paddr, 32'h0033_3000);
        chk("stall_hold_valid", 32'(data_valid), 32'd1);
        stall = 1'b0; data_ld(32'h0088_8010);
        step();
        chk("stall_write_took", data_paddr, 32'h0022_2010);
        data_req = 1'b0;

        // Random index with wired=5
        wired = 3'd5;
        wr_entry(3'd7, 20'h0, 8'd0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
        chk("rand_after_we", 32'(random_idx), 32'd7);
        step(); chk("rand_seq_6", 32'(random_idx), 32'd6);
        step(); chk("rand_seq_5", 32'(random_idx), 32'd5);
        step(); chk("rand_wrap_7", 32'(random_idx), 32'd7);
        step(); chk("rand_seq_6b", 32'(random_idx), 32'd6);
        stall = 1'b1;
        step(); step(); chk("rand_stall_hold", 32'(random_idx), 32'd6);
        stall = 1'b0;
        step(); chk("rand_resume_5", 32'(random_idx), 32'd5);
        wr_entry(3'd7, 20'h0, 8'd0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
        chk("rand_we_reload", 32'(random_idx), 32'd7);

        // Reset during a pending data request
        data_ld(32'h8000_0000);
        #2 rst_n = 1'b0;
        step();
        chk("rst_mid_data_valid", 32'(data_valid), 32'd0);
        data_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("rst_rel_data_valid", 32'(data_valid), 32'd0);
        chk("rst_rel_random", 32'(random_idx), 32'd6);
        data_ld(32'h0088_8010);
        step();
        chk("rst_entries_cleared", 32'(data_miss), 32'd1);
        data_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmu_tlb.md
MMU_TLB -- requirements
Module: mmu_tlb

Interface
REQ-001 Parameter TLB_ENTRIES, default 8, meaning number of fully-associative TLB entries (power of 2, 4..32).
REQ-002 Parameter ASID_W, default 8, meaning address-space-ID width.
REQ-003 Parameter IDX_W, default $clog2(TLB_ENTRIES), meaning entry index width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 stall  in  1  holds all response registers and the random counter.
REQ-007 cur_asid  in  ASID_W  current address-space ID.
REQ-008 inst_req / inst_vaddr  in  1/32  fetch translation request.
REQ-009 inst_valid / inst_paddr / inst_miss  out  1/32/1  fetch response.
REQ-010 data_req / data_wr / data_vaddr  in  1/1/32  load/store translation request.
REQ-011 data_valid / data_paddr / data_uncached / data_miss / data_mod  out  1/32/1/1/1  data response.
REQ-012 tlb_we / tlb_idx / tlb_vpn / tlb_asid / tlb_g / tlb_pfn / tlb_c / tlb_d / tlb_v  in  1/IDX_W/20/ASID_W/1/20/1/1/1  entry write port.
REQ-013 tlbp_req / tlbp_vpn  in  1/20  probe request, using cur_asid.
REQ-014 tlbp_valid / tlbp_idx / tlbp_miss  out  1/IDX_W/1  probe response.
REQ-015 tlb_flush  in  1  invalidate all entries.
REQ-016 wired  in  IDX_W  lower bound for the random index.
REQ-017 random_idx  out  IDX_W  replacement index for TLBWR.

Function
REQ-018 Every response (inst, data, probe) SHALL be registered: valid exactly 1 cycle after the request cycle, with no stall in that edge.
REQ-019 While stall=1, response registers and random_idx SHALL hold; tlb_we and tlb_flush SHALL still take effect.
REQ-020 A vaddr in 0x8000_0000-0x9FFF_FFFF (kseg0) SHALL map to paddr = vaddr & 0x1FFF_FFFF, uncached=0, miss=0.
REQ-021 A vaddr in 0xA000_0000-0xBFFF_FFFF (kseg1) SHALL map to paddr = vaddr & 0x1FFF_FFFF, uncached=1, miss=0.
REQ-022 Any other vaddr SHALL be translated via the TLB: hit when entry.v_bit set, entry.vpn == vaddr[31:12], and (entry.g or entry.asid == cur_asid).
REQ-023 On a hit, paddr = {pfn, vaddr[11:0]} and uncached = !entry.c.
REQ-024 On no hit, or a hit with v=0, miss=1 and paddr=0.
REQ-025 Multiple hits SHALL resolve to the lowest index.
REQ-026 A data_wr hit with d=0 SHALL assert data_mod=1 with miss=0.
REQ-027 inst and data lookups SHALL proceed in the same cycle independently (two compare banks).
REQ-028 A probe SHALL return the hit index with tlbp_miss=0, or tlbp_idx=0 with tlbp_miss=1.
REQ-029 tlb_we writes all fields of entry tlb_idx at the edge.
REQ-030 Lookups or probes in the same cycle as tlb_we SHALL see the pre-write contents.
REQ-031 tlb_flush SHALL clear every valid bit in one cycle; if tlb_we occurs in the same cycle, the written entry SHALL survive.
REQ-032 random_idx SHALL decrement each non-stalled cycle from TLB_ENTRIES-1 to wired, then wrap to TLB_ENTRIES-1.
REQ-033 random_idx SHALL load TLB_ENTRIES-1 on any tlb_we and whenever random_idx < wired.
REQ-034 A request deasserted in a cycle SHALL produce valid=0 in the following cycle; other outputs then hold their last values.

Reset
REQ-035 On rst=0, all entry valid bits SHALL be cleared; remaining entry fields are don't-care.
REQ-036 On rst=0, all *_valid, *_miss, data_mod and data_uncached outputs SHALL be 0, paddr outputs 0, and random_idx = TLB_ENTRIES-1.
REQ-037 Reset asserted mid-operation SHALL discard any pending response, with no valid pulse after release.

Structure
REQ-038 A shared package SHALL hold the segment boundary constants (KSEG0_BASE, KSEG1_BASE, KSEG_MASK = 0x1FFF_FFFF), the page offset width (12), and the TLB entry struct typedef.
REQ-039 One sub-module, tlb_match, SHALL implement a single-port combinational compare plus priority encode, instantiated three times (inst, data, probe).

Verification
REQ-040 After reset, inst_vaddr=0xBFC0_0000 -> next cycle: inst_valid=1, inst_paddr=0x1FC0_0000, miss=0; data 0x8000_1234 -> paddr 0x0000_1234, uncached=0.
REQ-041 Write idx 3 {vpn=0x00400, asid=5, g=0, pfn=0x01234, c=1, d=0, v=1}, cur_asid=5; data load 0x0040_0ABC -> paddr 0x0123_4ABC, miss=0; same address as store -> data_mod=1; cur_asid=6 -> data_miss=1.
REQ-042 Entries 2 and 6 both match vpn 0x00010 -> probe returns tlbp_idx=2; tlb_flush, then probe -> tlbp_miss=1.
REQ-043 tlb_we to idx 1 in the same cycle as a lookup of its new VPN -> miss; same lookup one cycle later -> hit.
REQ-044 wired=5, TLB_ENTRIES=8 -> random_idx sequence 7,6,5,7,...; holds under stall; a tlb_we reloads 7.
REQ-045 Assert rst low on the cycle after data_req -> data_valid=0 throughout reset and after release; random_idx=7.
